// File: rtl/y86_pkg.sv
// Shared constants for the Y86-64 run monitor.
//   - Core status codes (AOK/HLT/ADR/INS) as driven on the processor status bus.
//   - Monitor FSM state encoding (IDLE/RUN/DONE).
//   - Default width of the cycle counter.
package y86_pkg;

    localparam int unsigned CNT_W_DEFAULT = 32;

    localparam int unsigned STAT_AOK = 0;
    localparam int unsigned STAT_HLT = 1;
    localparam int unsigned STAT_ADR = 2;
    localparam int unsigned STAT_INS = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/y86_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset, forces q to 0
//   clr  - synchronous clear; when combined with en the counter loads 1
//   en   - count enable; holds at all-ones instead of wrapping
//   q    - counter value
module y86_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    logic [W-1:0] base;
    logic [W-1:0] q_next;

    always_comb begin
        base   = clr ? '0 : q;
        q_next = base;
        if (en && (base != {W{1'b1}})) begin
            q_next = base + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/y86_run_monitor.sv
// Run-control and termination monitor for a Y86-64 core.
// Arms on start, counts cycles in RUN, stops on a stable non-AOK status
// (held SETTLE consecutive cycles) or on the watchdog, and latches the verdict.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   start         - one-cycle pulse, arms from IDLE or DONE (ignored in RUN)
//   status        - core status: 0=AOK 1=HLT 2=ADR 3=INS
//   busy          - high in RUN
//   done          - high in DONE until start or reset
//   pass          - run ended on HLT without timeout
//   timeout       - run ended by the watchdog
//   final_status  - status accepted at termination, 0 on timeout
//   cycles        - cycles spent in RUN, frozen in DONE
// Optional feature: define Y86_MON_TRACE_EN for per-cycle simulation logging.
module y86_run_monitor
    import y86_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEFAULT,
    parameter int unsigned STAT_W  = 2,
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned SETTLE  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [STAT_W-1:0] status,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [STAT_W-1:0] final_status,
    output logic [CNT_W-1:0]  cycles
);

    localparam bit               WD_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [STAT_W-1:0] last_status;
    logic [3:0]        settle;
    logic [4:0]        settle_next_val;

    logic in_run;
    logic arm;
    logic is_aok;
    logic restart;
    logic accept;
    logic watchdog;

    assign in_run  = (state == ST_RUN);
    assign arm     = start && !in_run;
    assign is_aok  = (status == STAT_W'(STAT_AOK));
    // A different non-AOK code while already settling starts a fresh window.
    assign restart = (settle != 4'd0) && (status != last_status);

    assign settle_next_val = restart ? 5'd1 : ({1'b0, settle} + 5'd1);
    assign accept          = in_run && !is_aok && (settle_next_val == 5'(SETTLE));
    // Terminal acceptance takes priority over the watchdog on the same edge.
    assign watchdog        = in_run && WD_EN && (cycles == WD_LAST) && !accept;

    y86_sat_counter #(
        .W (CNT_W)
    ) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (arm),
        .en  (in_run && !watchdog),
        .q   (cycles)
    );

    y86_sat_counter #(
        .W (4)
    ) u_settle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (arm || (in_run && (is_aok || restart))),
        .en  (in_run && !is_aok),
        .q   (settle)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (accept || watchdog) state_next = ST_DONE;
            ST_DONE: if (start) state_next = ST_RUN;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            last_status  <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            final_status <= '0;
        end else begin
            state <= state_next;
            if (arm) begin
                last_status  <= '0;
                done         <= 1'b0;
                pass         <= 1'b0;
                timeout      <= 1'b0;
                final_status <= '0;
            end else if (in_run) begin
                last_status <= status;
                if (accept) begin
                    done         <= 1'b1;
                    pass         <= (status == STAT_W'(STAT_HLT));
                    timeout      <= 1'b0;
                    final_status <= status;
                end else if (watchdog) begin
                    done         <= 1'b1;
                    pass         <= 1'b0;
                    timeout      <= 1'b1;
                    final_status <= '0;
                end
            end
        end
    end

    assign busy = in_run;

`ifdef Y86_MON_TRACE_EN
    always @(posedge clk) begin
        if (!rst && in_run) begin
            $display("[y86_mon] cycle=%0d status=%0d", cycles, status);
            if (accept) begin
                $display("[y86_mon] end verdict=%s final_status=%0d cycles=%0d",
                         (status == STAT_W'(STAT_HLT)) ? "halt" : "error", status,
                         cycles + CNT_W'(1));
            end else if (watchdog) begin
                $display("[y86_mon] end verdict=timeout final_status=0 cycles=%0d", cycles);
            end
        end
    end
`endif

endmodule

// File: tb/tb_y86_run_monitor.sv
// Directed bench for y86_run_monitor with a sample-history reference model.
module tb_y86_run_monitor;

    localparam int unsigned A_TIMEOUT = 100;
    localparam int unsigned A_SETTLE  = 2;
    localparam int          B_MAX     = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  status = 2'd0;
    logic        start_b = 1'b0;
    logic [1:0]  status_b = 2'd0;

    logic        a_busy, a_done, a_pass, a_timeout;
    logic [1:0]  a_final;
    logic [31:0] a_cycles;
    logic        b_busy, b_done, b_pass, b_timeout;
    logic [1:0]  b_final;
    logic [3:0]  b_cycles;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    y86_run_monitor #(
        .CNT_W   (32),
        .STAT_W  (2),
        .TIMEOUT (A_TIMEOUT),
        .SETTLE  (A_SETTLE)
    ) dut_a (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .status       (status),
        .busy         (a_busy),
        .done         (a_done),
        .pass         (a_pass),
        .timeout      (a_timeout),
        .final_status (a_final),
        .cycles       (a_cycles)
    );

    y86_run_monitor #(
        .CNT_W   (4),
        .STAT_W  (2),
        .TIMEOUT (0),
        .SETTLE  (2)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .start        (start_b),
        .status       (status_b),
        .busy         (b_busy),
        .done         (b_done),
        .pass         (b_pass),
        .timeout      (b_timeout),
        .final_status (b_final),
        .cycles       (b_cycles)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model for dut_a: a run ends when the last SETTLE samples are the
    // same non-AOK code, otherwise when the watchdog limit is reached.
    bit     m_run, m_done, m_to;
    int     m_final;
    longint m_cyc;
    int     hist[$];
    bit     term;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 0; m_done = 0; m_to = 0; m_final = 0; m_cyc = 0;
            hist.delete();
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_done = 0; m_to = 0; m_final = 0; m_cyc = 0;
                hist.delete();
            end
        end else begin
            hist.push_back(int'(status));
            if (hist.size() > A_SETTLE) void'(hist.pop_front());
            term = (hist.size() == A_SETTLE) && (hist[0] != 0);
            foreach (hist[k]) if (hist[k] != hist[0]) term = 0;
            if (term) begin
                m_cyc = m_cyc + 1; m_run = 0; m_done = 1; m_final = hist[0];
            end else if (A_TIMEOUT != 0 && m_cyc == A_TIMEOUT - 1) begin
                m_run = 0; m_done = 1; m_to = 1; m_final = 0;
            end else begin
                m_cyc = m_cyc + 1;
            end
        end
    end

    // Model for dut_b: never terminates (status stays AOK, no watchdog), saturates.
    bit b_run;
    int b_cyc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            b_run = 0; b_cyc = 0;
        end else if (!b_run) begin
            if (start_b) begin b_run = 1; b_cyc = 0; end
        end else begin
            b_cyc = (b_cyc < B_MAX) ? b_cyc + 1 : B_MAX;
        end
    end

    always @(negedge clk) begin
        check("a_busy", a_busy, m_run);
        check("a_done", a_done, m_done);
        check("a_pass", a_pass, m_done && m_final == 1 && !m_to);
        check("a_timeout", a_timeout, m_to);
        check("a_final", a_final, m_final);
        check("a_cycles", a_cycles, m_cyc);
        check("b_busy", b_busy, b_run);
        check("b_done", b_done, 0);
        check("b_cycles", b_cycles, b_cyc);
    end

    task automatic arm_a();
        status = 2'd0;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_busy", a_busy, 0);
        check("reset_done", a_done, 0);
        check("reset_cycles", a_cycles, 0);
        rst = 1'b0;

        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;

        // Halt run, with a start pulse during RUN that must be ignored.
        arm_a();
        check("halt_arm_cycles", a_cycles, 0);
        check("halt_arm_busy", a_busy, 1);
        for (int i = 0; i < 50; i++) begin
            start = (i == 10);
            @(negedge clk);
        end
        start  = 1'b0;
        status = 2'd1;
        @(negedge clk);
        check("halt_not_yet_done", a_done, 0);
        @(negedge clk);
        check("halt_done", a_done, 1);
        check("halt_pass", a_pass, 1);
        check("halt_final", a_final, 1);
        check("halt_cycles", a_cycles, 52);
        status = 2'd2;
        repeat (3) @(negedge clk);
        check("halt_frozen_final", a_final, 1);
        check("halt_frozen_cycles", a_cycles, 52);

        // Restart from DONE, then a glitch followed by a held INS.
        arm_a();
        check("restart_cycles", a_cycles, 0);
        check("restart_done", a_done, 0);
        check("restart_pass", a_pass, 0);
        check("restart_final", a_final, 0);
        for (int i = 1; i <= 45; i++) begin
            status = (i == 20) ? 2'd2 : ((i >= 40) ? 2'd3 : 2'd0);
            @(negedge clk);
        end
        check("glitch_done", a_done, 1);
        check("glitch_final", a_final, 3);
        check("glitch_pass", a_pass, 0);
        check("glitch_timeout", a_timeout, 0);
        check("glitch_cycles", a_cycles, 41);

        // Watchdog.
        arm_a();
        repeat (99) @(negedge clk);
        check("wd_before_done", a_done, 0);
        check("wd_before_cycles", a_cycles, 99);
        @(negedge clk);
        check("wd_done", a_done, 1);
        check("wd_timeout", a_timeout, 1);
        check("wd_final", a_final, 0);
        check("wd_pass", a_pass, 0);
        check("wd_cycles", a_cycles, 99);

        // Settle completes on the watchdog edge: terminal status wins.
        arm_a();
        for (int i = 1; i <= 102; i++) begin
            status = (i >= 99) ? 2'd1 : 2'd0;
            @(negedge clk);
        end
        check("simul_timeout", a_timeout, 0);
        check("simul_final", a_final, 1);
        check("simul_pass", a_pass, 1);
        check("simul_cycles", a_cycles, 100);

        check("sat_cycles", b_cycles, 15);
        check("sat_done", b_done, 0);

        // Asynchronous reset in the middle of a run.
        arm_a();
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_busy", a_busy, 0);
        check("async_cycles", a_cycles, 0);
        check("async_done", a_done, 0);
        check("async_b_cycles", b_cycles, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("after_reset_idle", a_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
